// File: rtl/prio_enc_pkg.sv
// Shared constants and FSM encoding for the registered priority encoder/arbiter.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational priority pick: scans vec downward from start, wrapping N-1 -> 0 below index 0.
module prio_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int unsigned b;
    int unsigned p;
    // An out-of-range start (possible only if N is not a power of 2) falls back to the top index.
    b   = (rr && (32'(start) < N)) ? 32'(start) : N - 1;
    p   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      p = b + N - off;
      if (p >= N) p = p - N;
      if (!any && vec[p[W-1:0]]) begin
        any = 1'b1;
        idx = W'(p);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-input priority encoder with sticky request capture, valid/ack handshake
// and fixed or round-robin priority.
module prio_encoder_arb
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         vld,
  output logic [W-1:0] idx,
  output logic [N-1:0] gnt
);

  if (N < 2 || N > 64) begin : g_bad_n
    $error("prio_encoder_arb: N must be in 2..64");
  end
  if (MODE != MODE_FIXED && MODE != MODE_RR) begin : g_bad_mode
    $error("prio_encoder_arb: MODE must be 0 or 1");
  end

  state_t       state;
  logic [N-1:0] pend;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] pick_oh;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         accept;

  assign accept  = (state == ST_GRANT) && ack;
  assign clr     = accept ? gnt : '0;
  assign cand    = (pend & ~clr) | req;
  assign ptr_nxt = (idx == '0) ? W'(N - 1) : idx - W'(1);
  // On an accepted grant the next pick already searches from the advanced pointer,
  // so back-to-back round-robin grants rotate every cycle.
  assign start   = accept ? ptr_nxt : ptr;
  assign pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec   (cand),
    .start (start),
    .rr    (MODE == MODE_RR),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pend  <= '0;
      ptr   <= W'(N - 1);
      vld   <= 1'b0;
      idx   <= '0;
      gnt   <= '0;
    end else begin
      pend <= cand;
      if (accept) ptr <= ptr_nxt;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state <= ST_GRANT;
            vld   <= 1'b1;
            idx   <= pick_idx;
            gnt   <= pick_oh;
          end
        end
        ST_GRANT: begin
          if (ack) begin
            if (pick_any) begin
              idx <= pick_idx;
              gnt <= pick_oh;
            end else begin
              state <= ST_IDLE;
              vld   <= 1'b0;
              gnt   <= '0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          vld   <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Self-checking bench: three arbiters (N=8 fixed, N=8 round-robin, N=5 round-robin)
// compared every cycle against a queue-free behavioural model plus directed constants.
module tb_prio_encoder_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_req [3];
  logic        m_ack [3];

  logic       vld0, vld1, vld2;
  logic [2:0] idx0, idx1, idx2;
  logic [7:0] gnt0, gnt1;
  logic [4:0] gnt2;

  int n_tests = 0;
  int n_fail  = 0;

  int n_of    [3] = '{8, 8, 5};
  int mode_of [3] = '{0, 1, 1};

  logic [63:0] r_pend [3];
  bit          r_busy [3];
  int          r_cur  [3];
  int          r_ptr  [3];

  always #5 clk = ~clk;

  prio_encoder_arb #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(m_req[0][7:0]), .ack(m_ack[0]),
    .vld(vld0), .idx(idx0), .gnt(gnt0));
  prio_encoder_arb #(.N(8), .MODE(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(m_req[1][7:0]), .ack(m_ack[1]),
    .vld(vld1), .idx(idx1), .gnt(gnt1));
  prio_encoder_arb #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(m_req[2][4:0]), .ack(m_ack[2]),
    .vld(vld2), .idx(idx2), .gnt(gnt2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First set bit found walking down from start, wrapping modulo n.
  function automatic int ref_pick(input logic [63:0] v, input int n, input int start);
    for (int k = 0; k < n; k++) begin
      int i = (start - k + n) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      r_pend[d] = '0;
      r_busy[d] = 1'b0;
      r_cur[d]  = 0;
      r_ptr[d]  = n_of[d] - 1;
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 3; d++) begin
      logic [63:0] mask = (64'd1 << n_of[d]) - 64'd1;
      bit          acc  = r_busy[d] && m_ack[d];
      int          p;
      if (acc) begin
        r_pend[d] &= ~(64'd1 << r_cur[d]);
        r_ptr[d]   = (r_cur[d] == 0) ? n_of[d] - 1 : r_cur[d] - 1;
      end
      r_pend[d] |= m_req[d] & mask;
      if (!r_busy[d] || acc) begin
        p = ref_pick(r_pend[d], n_of[d], (mode_of[d] == 1) ? r_ptr[d] : n_of[d] - 1);
        if (p < 0) r_busy[d] = 1'b0;
        else begin
          r_busy[d] = 1'b1;
          r_cur[d]  = p;
        end
      end
    end
  endfunction

  task automatic check_dut(input int d, input logic v, input logic [63:0] i, input logic [63:0] g);
    check($sformatf("vld%0d", d), 64'(v), 64'(r_busy[d]));
    check($sformatf("idx%0d", d), i, 64'(r_cur[d]));
    check($sformatf("gnt%0d", d), g, r_busy[d] ? (64'd1 << r_cur[d]) : 64'd0);
  endtask

  task automatic check_all();
    check_dut(0, vld0, 64'(idx0), 64'(gnt0));
    check_dut(1, vld1, 64'(idx1), 64'(gnt1));
    check_dut(2, vld2, 64'(idx2), 64'(gnt2));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_all(input logic [63:0] r, input logic a);
    for (int d = 0; d < 3; d++) begin
      m_req[d] = r;
      m_ack[d] = a;
    end
  endtask

  int e1 [6] = '{7, 0, 7, 0, 7, 0};
  int e2 [6] = '{4, 3, 2, 1, 0, 4};
  int e0 [3] = '{5, 2, 1};
  int g0 [3] = '{8'h20, 8'h04, 8'h02};

  initial begin
    rst_n = 1'b0;
    set_all('0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_vld", 64'(vld0), 64'd0);
    check("rst_gnt", 64'(gnt0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_all('0, 1'b1);
    repeat (2) cycle();
    check("no_req_vld", 64'(vld0), 64'd0);

    // Fixed burst on u_fix, alternating pair on u_rr8, full wrap on u_rr5.
    for (int k = 0; k < 6; k++) begin
      m_req[0] = (k == 0) ? 64'h26 : 64'h0;
      m_req[1] = 64'h81;
      m_req[2] = 64'h1F;
      for (int d = 0; d < 3; d++) m_ack[d] = 1'b1;
      cycle();
      if (k < 3) begin
        check("fix_idx", 64'(idx0), 64'(e0[k]));
        check("fix_gnt", 64'(gnt0), 64'(g0[k]));
      end else begin
        check("fix_drain", 64'(vld0), 64'd0);
      end
      check("rr8_idx", 64'(idx1), 64'(e1[k]));
      check("rr8_vld", 64'(vld1), 64'd1);
      check("rr5_idx", 64'(idx2), 64'(e2[k]));
    end

    set_all('0, 1'b1);
    repeat (8) cycle();

    // Held grant: no preemption while ack is low.
    set_all('0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      m_req[0] = (k == 0) ? 64'h10 : (k == 2) ? 64'h80 : 64'h0;
      cycle();
      check("hold_idx", 64'(idx0), 64'd4);
      check("hold_vld", 64'(vld0), 64'd1);
    end
    m_req[0] = '0;
    m_ack[0] = 1'b1;
    cycle();
    check("hold_next", 64'(idx0), 64'd7);
    cycle();
    check("hold_end", 64'(vld0), 64'd0);

    // Asynchronous reset while round-robin grant is active.
    set_all('0, 1'b0);
    m_req[1] = 64'h0F;
    cycle();
    m_req[1] = '0;
    cycle();
    check("pre_rst_vld", 64'(vld1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_vld", 64'(vld1), 64'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    m_req[1] = 64'h09;
    m_ack[1] = 1'b1;
    cycle();
    check("post_rst_idx", 64'(idx1), 64'd3);
    m_req[1] = '0;
    repeat (4) cycle();

    // Randomized traffic with occasional mid-cycle resets.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        m_req[d] = ($urandom_range(0, 2) == 0) ? 64'h0 : 64'({$urandom, $urandom} & {$urandom, $urandom});
        m_ack[d] = ($urandom_range(0, 3) != 0);
      end
      cycle();
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_arb.md
# prio_encoder_arb

Parametrised, registered N-input priority encoder with sticky request capture, a valid/ack output handshake, and selectable fixed or round-robin priority. It generalises the combinational 4:2 priority encoder to arbitrary width. It sits between a bank of request sources and a single shared consumer, and emits one binary index per accepted grant.

## Interface

Parameters:
- `N`, default 8: number of request inputs; legal range 2..64, and need not be a power of 2.
- `MODE`, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- `W`, localparam, equal to `$clog2(N)`: width of the index output.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: request vector; a one-cycle pulse is sufficient because it is captured.
- `ack`, input, 1: consumer accepts the current grant when `vld` is high.
- `vld`, output, 1: a grant is presented; the encoder equivalent of `Vld`.
- `idx`, output, W: binary index of the granted request.
- `gnt`, output, N: one-hot form of `idx`; all zeros when `vld` is low.

## Operation

State:
- `pend[N-1:0]` holds sticky requests.
- FSM has two states, IDLE and GRANT.
- Round-robin pointer `ptr[W-1:0]`, used only when `MODE=1`.

Definitions:
- Candidate vector: `cand = pend | req`.
- Clear mask: `clr = gnt` when `vld & ack`, else 0.
- Pending update every cycle: `pend <= (pend & ~clr) | req`. A new request on the index being acknowledged in the same cycle is re-captured.

Selection is `pick(cand_eff)`:
- Fixed mode: highest set index.
- Round-robin mode: search starts at `ptr` and descends, wrapping from 0 to N-1; the first set bit wins.

FSM:
- IDLE, `cand == 0`: stay in IDLE; `vld=0`.
- IDLE, `cand != 0`: register `idx = pick(cand)` and set `vld=1`; go to GRANT.
- GRANT, `ack=0`: hold `idx`, `gnt` and `vld` stable. New requests only update `pend`; there is no preemption, even by a higher priority.
- GRANT, `ack=1`: set `cand_eff = (pend & ~clr) | req`.
  - If `cand_eff != 0`, load `idx = pick(cand_eff)` and stay in GRANT. This is back-to-back operation at one grant per cycle.
  - Else drop `vld` and go to IDLE.
- `ptr` updates only on an accepted grant: `ptr <= (idx == 0) ? N-1 : idx-1`. In fixed mode `ptr` is ignored.
- For `N` not a power of 2, index values at or above `N` never appear, and `ptr` wraps at N-1.
- Reset values: `vld=0`, `idx=0`, `gnt=0`, `pend=0`, `ptr=N-1`, FSM in IDLE. With `ptr=N-1` the first round-robin decision matches fixed mode.

## Timing

- Latency: a `req` high before rising edge k gives `vld=1` and a valid `idx` after edge k, i.e. one cycle.
- Outputs are driven only from registers; there is no combinational path from `req` or `ack` to any output.
- Throughput: one grant per cycle while `ack` is held high and candidates remain.
- Reset in the middle of a grant: `rst_n` low forces all outputs and state to their reset values immediately, without waiting for a clock. Requests pending at that point are lost. Operation resumes on the first edge after `rst_n` is released.
- `ack` while `vld=0` is ignored.
- A `req` bit already set in `pend` has no further effect; requests are not counted.

## Structure

- Shared package `prio_enc_pkg` holds:
  - Constants `MODE_FIXED=0` and `MODE_RR=1`.
  - The FSM state encoding, `ST_IDLE` and `ST_GRANT`.
- Sub-module `prio_pick` is combinational and parametrised by `N` and `W`.
  - Inputs: `vec[N-1:0]`, `start[W-1:0]`, `rr`.
  - Outputs: `idx`, `any`.
  - Implementation: a rotate-and-scan search, with `start` tied to N-1 when `rr=0`.
  - It is instantiated once in the top level.

## Test plan

1. Reset with N=8: assert `rst_n=0` mid-run, then release. Expect `vld=0`, `idx=0`, `gnt=8'h00` during reset, and no grant until the first `req`.
2. Fixed mode, N=8: pulse `req=8'h26` for one cycle with `ack=1`. Expect `idx` = 5, 2, 1 on three consecutive cycles, `gnt` = 8'h20, 8'h04, 8'h02, then `vld=0`.
3. Round-robin mode, N=8: hold `req=8'h81` with `ack=1`. Expect `idx` = 7, 0, 7, 0 with `vld` continuously high.
4. Hold, fixed mode: `req=8'h10` with `ack=0` for 5 cycles. Expect `idx=4`, `vld=1` held stable. Pulse `req=8'h80` during the hold: `idx` stays 4. Then `ack=1` for 1 cycle: next `idx=7`, then `vld=0`.
5. Reset during a grant in round-robin mode: drop `rst_n` while `vld=1` and `pend=8'h0F`. Expect `vld` to fall without a clock edge. After release, `req=8'h09` gives `idx=3`, showing `ptr=N-1` and `pend` cleared.
6. Non-power-of-2, N=5, round-robin: hold `req=5'h1F` with `ack=1`. Expect `idx` = 4, 3, 2, 1, 0, 4 (wrap) and never a value of 5 or above.
